// File: rtl/instr_encoder_pkg.sv
// Shared RV32I constants and the load-session state type for the instruction encoder.
package riscv_isa_pkg;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input, instruction-memory write port and session status of the encoder.
interface instr_encoder_if #(parameter int DEPTH = 64) ();

   logic                         start;
   logic                         finish;
   logic                         in_valid;
   logic                         in_ready;
   logic [2:0]                   fmt;
   logic [6:0]                   opcode;
   logic [4:0]                   rd;
   logic [4:0]                   rs1;
   logic [4:0]                   rs2;
   logic [2:0]                   funct3;
   logic [6:0]                   funct7;
   logic [31:0]                  imm;
   logic                         imem_we;
   logic [31:0]                  imem_addr;
   logic [31:0]                  imem_wdata;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         busy;
   logic                         done;
   logic                         err;

   modport master (
      output start, finish, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
      input  in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
   );

   modport slave (
      input  start, finish, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
      output in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
   );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packer: builds the 32-bit word for a format and flags
// bundles that cannot be encoded (reserved format, odd branch/jump offset).
module instr_pack
   import riscv_isa_pkg::*;
(
   input  logic [2:0]  fmt_i,
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   always_comb begin
      word_o    = 32'h0000_0000;
      illegal_o = 1'b0;
      case (fmt_i)
         FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
         FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         FMT_B: begin
            word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], opcode_i};
            illegal_o = imm_i[0];
         end
         FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
         FMT_J: begin
            word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            illegal_o = imm_i[0];
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Load-session encoder: accepts field bundles, packs them and streams the words
// into instruction memory at consecutive addresses through a registered write port.
module instr_encoder
   import riscv_isa_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   instr_encoder_if.slave bus
);

   localparam int             CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]  ONE_C   = CW'(1);

   state_e         state_q, state_d;
   logic [31:0]    addr_q, addr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           err_q, err_d;
   logic           we_q, we_d;
   logic [31:0]    waddr_q, waddr_d;
   logic [31:0]    wdata_q, wdata_d;

   logic           in_ready_s;
   logic           busy_s;
   logic           done_s;
   logic           accept_s;
   logic           illegal_s;
   logic [31:0]    word_s;

   instr_pack u_pack (
      .fmt_i     (bus.fmt),
      .opcode_i  (bus.opcode),
      .rd_i      (bus.rd),
      .rs1_i     (bus.rs1),
      .rs2_i     (bus.rs2),
      .funct3_i  (bus.funct3),
      .funct7_i  (bus.funct7),
      .imm_i     (bus.imm),
      .word_o    (word_s),
      .illegal_o (illegal_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The full-session exit looks at the registered count, one cycle after the last write.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_LOAD;
            else           state_d = ST_IDLE;
         end
         ST_LOAD: begin
            if (bus.start)                              state_d = ST_LOAD;
            else if (bus.finish || (count_q == DEPTH_C)) state_d = ST_DONE;
            else                                        state_d = ST_LOAD;
         end
         ST_DONE: begin
            if (bus.start) state_d = ST_LOAD;
            else           state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_s     = (state_q == ST_LOAD);
      done_s     = (state_q == ST_DONE);
      in_ready_s = busy_s && (count_q < DEPTH_C) && !bus.start && !bus.finish;
   end

   assign accept_s = bus.in_valid && in_ready_s;

   // A start always wins: the session is re-armed and any same-cycle bundle is lost.
   always_comb begin
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (bus.start) begin
         addr_d  = BASE_ADDR;
         count_d = {CW{1'b0}};
         err_d   = 1'b0;
      end else if (accept_s) begin
         if (illegal_s) begin
            err_d = 1'b1;
         end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word_s;
            addr_d  = addr_q + 32'd4;
            count_d = count_q + ONE_C;
         end
      end else begin
         addr_d = addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= BASE_ADDR;
         count_q <= {CW{1'b0}};
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
      end else begin
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = waddr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.count      = count_q;
   assign bus.busy       = busy_s;
   assign bus.done       = done_s;
   assign bus.err        = err_q;

endmodule
